// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: sizing constants,
// FSM state encoding and the latched layer descriptor.
package layer_sequencer_pkg;

  localparam int NU_COUNT      = 8;
  localparam int XY_MEM_DEPTH  = 8;
  localparam int W_MEM_DEPTH   = 10;
  localparam int ACT_MASK_SIZE = 2;
  localparam int DRAIN_CYCLES  = 2;

  // xy addresses carry one extra MSB selecting the output memory
  localparam int XY_W = XY_MEM_DEPTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    SERIAL,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [XY_W-1:0]          in_count;
    logic [XY_W-1:0]          out_count;
    logic [XY_W-1:0]          x_base;
    logic [XY_W-1:0]          y_base;
    logic [W_MEM_DEPTH-1:0]   w_base;
    logic [ACT_MASK_SIZE-1:0] act_mask;
  } layer_desc_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Bundle between the instruction decoder (master), the layer sequencer (slave)
// and the datapath strobes it drives.
interface layer_sequencer_if;
  import layer_sequencer_pkg::*;

  // Handshake: a descriptor is taken on a rising edge where start & ready & !abort;
  // ready is high only in IDLE, start while not ready is dropped (never queued).
  logic                     start;
  logic                     ready;
  logic                     abort;
  logic [XY_W-1:0]          cfg_in_count;
  logic [XY_W-1:0]          cfg_out_count;
  logic [XY_W-1:0]          cfg_x_base;
  logic [XY_W-1:0]          cfg_y_base;
  logic [W_MEM_DEPTH-1:0]   cfg_w_base;
  logic [ACT_MASK_SIZE-1:0] cfg_act_mask;
  logic                     busy;
  logic                     done;

  logic [XY_W-1:0]          xy_read_addr;
  logic [W_MEM_DEPTH-1:0]   w_read_addr;
  logic                     mac_acc_update;
  logic                     mac_acc_loopback;
  logic                     serializer_update;
  logic                     serializer_shift;
  logic                     xy_write_enable;
  logic [XY_W-1:0]          xy_write_addr;
  logic [ACT_MASK_SIZE-1:0] act_mask;

  seq_state_t               state_dbg;

  modport slave (
    input  start, abort, cfg_in_count, cfg_out_count, cfg_x_base, cfg_y_base,
           cfg_w_base, cfg_act_mask,
    output ready, busy, done, xy_read_addr, w_read_addr, mac_acc_update,
           mac_acc_loopback, serializer_update, serializer_shift, xy_write_enable,
           xy_write_addr, act_mask, state_dbg
  );

  modport master (
    output start, abort, cfg_in_count, cfg_out_count, cfg_x_base, cfg_y_base,
           cfg_w_base, cfg_act_mask,
    input  ready, busy, done, xy_read_addr, w_read_addr, mac_acc_update,
           mac_acc_loopback, serializer_update, serializer_shift, xy_write_enable,
           xy_write_addr, act_mask, state_dbg
  );

endinterface

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: per neuron group, N MAC cycles, a drain gap,
// then V serializer/write-back cycles. All strobes decode from registered state.
module layer_sequencer
  import layer_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  layer_sequencer_if.slave  seq
);

  localparam int JW = $clog2(NU_COUNT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [XY_W-1:0] NU_XY      = XY_W'(NU_COUNT);
  localparam logic [XY_W-1:0] ONE_XY     = XY_W'(1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  seq_state_t             state_q, state_d;
  layer_desc_t            desc_q, desc_d;
  layer_desc_t            cfg;
  logic [XY_W-1:0]        k_q, k_d;
  logic [XY_W-1:0]        g_q, g_d;
  logic [XY_W-1:0]        rem_q, rem_d;
  logic [JW-1:0]          j_q, j_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [W_MEM_DEPTH-1:0] w_ptr_q, w_ptr_d;

  logic [XY_W-1:0]        v_last;
  logic                   last_group;

  always_comb begin
    cfg           = '0;
    cfg.in_count  = seq.cfg_in_count;
    cfg.out_count = seq.cfg_out_count;
    cfg.x_base    = seq.cfg_x_base;
    cfg.y_base    = seq.cfg_y_base;
    cfg.w_base    = seq.cfg_w_base;
    cfg.act_mask  = seq.cfg_act_mask;
  end

  // rem_q holds the neurons not yet serialized, M - g*NU_COUNT
  assign last_group = (rem_q <= NU_XY);
  assign v_last     = last_group ? (rem_q - ONE_XY) : (NU_XY - ONE_XY);

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    k_d     = k_q;
    g_d     = g_q;
    rem_d   = rem_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    w_ptr_d = w_ptr_q;

    seq.ready             = 1'b0;
    seq.busy              = 1'b1;
    seq.done              = 1'b0;
    seq.xy_read_addr      = '0;
    seq.w_read_addr       = '0;
    seq.mac_acc_update    = 1'b0;
    seq.mac_acc_loopback  = 1'b0;
    seq.serializer_update = 1'b0;
    seq.serializer_shift  = 1'b0;
    seq.xy_write_enable   = 1'b0;
    seq.xy_write_addr     = '0;
    seq.act_mask          = '0;
    seq.state_dbg         = state_q;

    unique case (state_q)
      IDLE: begin
        seq.ready = 1'b1;
        seq.busy  = 1'b0;
        if (seq.start && !seq.abort) begin
          desc_d  = cfg;
          k_d     = '0;
          g_d     = '0;
          j_d     = '0;
          dcnt_d  = '0;
          rem_d   = cfg.out_count;
          w_ptr_d = cfg.w_base;
          state_d = (cfg.in_count == '0 || cfg.out_count == '0) ? DONE : MAC;
        end
      end

      MAC: begin
        seq.mac_acc_update   = 1'b1;
        seq.mac_acc_loopback = (k_q != '0);
        seq.xy_read_addr     = desc_q.x_base + k_q;
        seq.w_read_addr      = w_ptr_q;
        // w_ptr runs across groups, so group g starts at w_base + g*N
        w_ptr_d = w_ptr_q + 1'b1;
        if (k_q == desc_q.in_count - ONE_XY) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + ONE_XY;
        end
      end

      DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          j_d     = '0;
          state_d = SERIAL;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      SERIAL: begin
        seq.serializer_update = (j_q == '0);
        seq.serializer_shift  = (j_q != '0);
        seq.xy_write_enable   = 1'b1;
        seq.xy_write_addr     = desc_q.y_base + g_q * NU_XY + XY_W'(j_q);
        seq.act_mask          = desc_q.act_mask;
        if (XY_W'(j_q) == v_last) begin
          if (last_group) begin
            state_d = DONE;
          end else begin
            g_d     = g_q + ONE_XY;
            rem_d   = rem_q - NU_XY;
            k_d     = '0;
            state_d = MAC;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      DONE: begin
        seq.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Cancel wins over every transition above; pending writes are simply dropped
    if (seq.abort && state_q != IDLE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      desc_q  <= '0;
      k_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      j_q     <= '0;
      dcnt_q  <= '0;
      w_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      k_q     <= k_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      w_ptr_q <= w_ptr_d;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: cycle-exact expectations for each scenario,
// compared through immediate assertions.
module tb_layer_sequencer;

  logic clk;
  logic rst_n;
  layer_sequencer_if sif ();

  layer_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .seq   (sif)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       upd;
    logic       lb;
    logic       su;
    logic       ss;
    logic       we;
    logic [8:0] xr;
    logic [9:0] wr;
    logic [8:0] wa;
    logic [1:0] am;
  } obs_t;

  int n_cmp;
  int n_err;
  int n_done;
  int n_wr;
  bit cnt_clr;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      n_done <= 0;
      n_wr   <= 0;
    end else begin
      if (sif.done === 1'b1) n_done <= n_done + 1;
      if (sif.xy_write_enable === 1'b1) n_wr <= n_wr + 1;
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.ready = sif.ready;
    o.busy  = sif.busy;
    o.done  = sif.done;
    o.upd   = sif.mac_acc_update;
    o.lb    = sif.mac_acc_loopback;
    o.su    = sif.serializer_update;
    o.ss    = sif.serializer_shift;
    o.we    = sif.xy_write_enable;
    o.xr    = sif.xy_read_addr;
    o.wr    = sif.w_read_addr;
    o.wa    = sif.xy_write_addr;
    o.am    = sif.act_mask;
    return o;
  endfunction

  function automatic obs_t f_idle();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t f_gap();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t f_done();
    obs_t o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    return o;
  endfunction

  function automatic obs_t f_mac(logic [8:0] xr, logic [9:0] wr, logic lb);
    obs_t o = '0;
    o.busy = 1'b1;
    o.upd  = 1'b1;
    o.lb   = lb;
    o.xr   = xr;
    o.wr   = wr;
    return o;
  endfunction

  function automatic obs_t f_ser(logic first, logic [8:0] wa, logic [1:0] am);
    obs_t o = '0;
    o.busy = 1'b1;
    o.su   = first;
    o.ss   = !first;
    o.we   = 1'b1;
    o.wa   = wa;
    o.am   = am;
    return o;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic set_cfg(input logic [8:0] n, input logic [8:0] m, input logic [8:0] x,
                         input logic [9:0] w, input logic [8:0] y, input logic [1:0] am);
    sif.cfg_in_count  = n;
    sif.cfg_out_count = m;
    sif.cfg_x_base    = x;
    sif.cfg_w_base    = w;
    sif.cfg_y_base    = y;
    sif.cfg_act_mask  = am;
  endtask

  task automatic launch(input logic [8:0] n, input logic [8:0] m, input logic [8:0] x,
                        input logic [9:0] w, input logic [8:0] y, input logic [1:0] am);
    set_cfg(n, m, x, w, y, am);
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic expect_mac(input string tag, input logic [8:0] xb, input logic [9:0] wb,
                            input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      chk($sformatf("%s_mac%0d", tag, k), f_mac(9'(xb + k), 10'(wb + k), k != 0));
      step();
    end
  endtask

  task automatic expect_gap(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_drain%0d", tag, d), f_gap());
      step();
    end
  endtask

  task automatic expect_ser(input string tag, input logic [8:0] yb, input int v,
                            input logic [1:0] am);
    for (int j = 0; j < v; j++) begin
      chk($sformatf("%s_ser%0d", tag, j), f_ser(j == 0, 9'(yb + j), am));
      step();
    end
  endtask

  task automatic expect_end(input string tag);
    chk({tag, "_done"}, f_done());
    step();
    chk({tag, "_idle"}, f_idle());
  endtask

  // case 1 body after the accepting edge: N=3, M=8, x=0x10, w=0, y=0x40, mask 1
  task automatic expect_case1(input string tag);
    expect_mac(tag, 9'h010, 10'h000, 0, 3);
    expect_gap(tag);
    expect_ser(tag, 9'h040, 8, 2'd1);
    expect_end(tag);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cnt_clr = 1'b1;
    rst_n   = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    set_cfg('0, '0, '0, '0, '0, '0);
    #12;
    chk("reset_state", f_idle());
    rst_n = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("idle_after_reset", f_idle());

    // 1: single full group
    clear_counts();
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_case1("c1");
    chk_int("c1_done_count", n_done, 1);
    chk_int("c1_write_count", n_wr, 8);

    // 2: two groups, second one partial, weight pointer continues across groups
    clear_counts();
    launch(9'd2, 9'd10, 9'h020, 10'h100, 9'h080, 2'd2);
    expect_mac("c2g0", 9'h020, 10'h100, 0, 2);
    expect_gap("c2g0");
    expect_ser("c2g0", 9'h080, 8, 2'd2);
    expect_mac("c2g1", 9'h020, 10'h102, 0, 2);
    expect_gap("c2g1");
    expect_ser("c2g1", 9'h088, 2, 2'd2);
    expect_end("c2");
    chk_int("c2_done_count", n_done, 1);
    chk_int("c2_write_count", n_wr, 10);

    // 3: empty layers finish immediately without strobes
    clear_counts();
    launch(9'd0, 9'd5, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_end("c3a");
    launch(9'd4, 9'd0, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_end("c3b");
    chk_int("c3_done_count", n_done, 2);
    chk_int("c3_write_count", n_wr, 0);

    // 4: abort in the 2nd MAC cycle, then an immediate clean rerun
    clear_counts();
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_mac("c4", 9'h010, 10'h000, 0, 1);
    chk("c4_mac1", f_mac(9'h011, 10'h001, 1'b1));
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    chk("c4_abort_idle", f_idle());
    chk_int("c4_no_done", n_done, 0);
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_case1("c4r");
    chk_int("c4_done_count", n_done, 1);

    // 5: asynchronous reset mid-SERIAL, start held off while reset is low
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_mac("c5", 9'h010, 10'h000, 0, 3);
    expect_gap("c5");
    expect_ser("c5", 9'h040, 2, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c5_async_reset", f_idle());
    set_cfg(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    sif.start = 1'b1;
    step();
    chk("c5_start_in_reset0", f_idle());
    step();
    chk("c5_start_in_reset1", f_idle());
    sif.start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("c5_released", f_idle());
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    expect_case1("c5r");

    // 6: start pulsed and cfg changed while busy leave the layer unchanged
    clear_counts();
    launch(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    sif.start = 1'b1;
    set_cfg(9'd7, 9'd3, 9'h155, 10'h2AA, 9'h0F0, 2'd3);
    expect_mac("c6", 9'h010, 10'h000, 0, 2);
    sif.start = 1'b0;
    expect_mac("c6", 9'h010, 10'h000, 2, 1);
    expect_gap("c6");
    expect_ser("c6", 9'h040, 8, 2'd1);
    expect_end("c6");
    chk_int("c6_done_count", n_done, 1);
    chk_int("c6_write_count", n_wr, 8);
    set_cfg(9'd3, 9'd8, 9'h010, 10'h000, 9'h040, 2'd1);
    sif.start = 1'b1;
    sif.abort = 1'b1;
    step();
    chk("c6_start_abort0", f_idle());
    sif.start = 1'b0;
    sif.abort = 1'b0;
    step();
    chk("c6_start_abort1", f_idle());

    // 7: address wrap on x, w and y
    launch(9'd4, 9'd2, 9'h1FE, 10'h3FE, 9'h1FF, 2'd3);
    expect_mac("c7", 9'h1FE, 10'h3FE, 0, 4);
    expect_gap("c7");
    expect_ser("c7", 9'h1FF, 2, 2'd3);
    expect_end("c7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
